// File: rtl/mudv_pkg.sv
// rtl/mudv_pkg.sv - shared types and codes for the MUDV command sequencer
package mudv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        RD_HI,
        RD_LO,
        DONE
    } state_t;

    localparam logic [3:0] F_EXEC_MUL = 4'b1001;
    localparam logic [3:0] F_EXEC_DIV = 4'b1011;
    localparam logic [3:0] F_RD_HI    = 4'b1000;
    localparam logic [3:0] F_RD_LO    = 4'b0000;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser, stable-count debouncer and press pulse
module key_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle agreeing with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= level_q & ~level_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mudv_sequencer.sv
// rtl/mudv_sequencer.sv - button-driven execute/read-back sequencer for the MUDV unit
module mudv_sequencer #(
    parameter int         N          = 3,
    parameter int         DEBOUNCE   = 16,
    parameter logic [3:0] F_EXEC_MUL = mudv_pkg::F_EXEC_MUL,
    parameter logic [3:0] F_EXEC_DIV = mudv_pkg::F_EXEC_DIV,
    parameter logic [3:0] F_RD_HI    = mudv_pkg::F_RD_HI,
    parameter logic [3:0] F_RD_LO    = mudv_pkg::F_RD_LO
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_n,
    input  logic [N-1:0] sw_a,
    input  logic [N-1:0] sw_b,
    input  logic         sw_op,
    input  logic [N-1:0] y,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   f,
    output logic         step,
    output logic [N-1:0] res_hi,
    output logic [N-1:0] res_lo,
    output logic         busy,
    output logic         done,
    output logic         err
);

    import mudv_pkg::*;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [N-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic         op_q, op_d, err_q, err_d;
    logic         press;
    logic         step_c;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_n),
        .press_o (press)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        err_d    = err_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        f        = F_RD_LO;
        step_c   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    a_d     = sw_a;
                    b_d     = sw_b;
                    op_d    = sw_op;
                    err_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                // A zero divisor never reaches MUDV; results are forced to zero.
                if (op_q == OP_DIV && b_q == '0) begin
                    err_d    = 1'b1;
                    res_hi_d = '0;
                    res_lo_d = '0;
                    state_d  = DONE;
                end else begin
                    f       = (op_q == OP_DIV) ? F_EXEC_DIV : F_EXEC_MUL;
                    step_c  = 1'b1;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                busy     = 1'b1;
                f        = F_RD_HI;
                res_hi_d = y;
                state_d  = RD_LO;
            end
            RD_LO: begin
                busy     = 1'b1;
                f        = F_RD_LO;
                res_lo_d = y;
                state_d  = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            err_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            err_q    <= err_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    // MUDV must never see a write in a cycle that is being reset.
    assign step   = step_c & ~reset;
    assign a      = a_q;
    assign b      = b_q;
    assign err    = err_q;
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;

endmodule
